// File: rtl/dla_seq_pkg.sv
// rtl/dla_seq_pkg.sv - shared types and constants for the DLA command sequencer
package dla_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_MAP,
    ST_WR_SH1,
    ST_WR_SH2,
    ST_WR_START,
    ST_WAIT_DONE,
    ST_WR_CLEAR,
    ST_SETTLE,
    ST_ERROR
  } seq_state_e;

  localparam logic [1:0] WSEL_MAP   = 2'd0;
  localparam logic [1:0] WSEL_SH1   = 2'd1;
  localparam logic [1:0] WSEL_SH2   = 2'd2;
  localparam logic [1:0] WSEL_OPCFG = 2'd3;

  localparam int DESC_W     = 128;
  localparam int MAP_LSB    = 0;
  localparam int SH1_LSB    = 32;
  localparam int SH2_LSB    = 64;
  localparam int OPCFG_LSB  = 96;

  localparam int          OPCFG_START_BIT = 0;
  localparam logic [31:0] START_MASK      = 32'd1 << OPCFG_START_BIT;

  // Extract one 32-bit register word from a descriptor.
  function automatic logic [31:0] desc_word(input logic [DESC_W-1:0] d, input int lsb);
    return d[lsb +: 32];
  endfunction

endpackage

// File: rtl/dla_desc_fifo.sv
// rtl/dla_desc_fifo.sv - DEPTH x WIDTH descriptor FIFO with wrap-bit pointers
module dla_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Full/empty come only from the pointer flops, so ready never depends on pop.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop in the same cycle both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dla_cmd_sequencer.sv
// rtl/dla_cmd_sequencer.sv - queues layer descriptors and programs the DLA control registers
module dla_cmd_sequencer
  import dla_seq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [127:0]      desc_data,
  output logic              ctrl_reg_w_en,
  output logic [1:0]        ctrl_reg_wsel,
  output logic [31:0]       ctrl_reg_wdata,
  input  logic              dla_done,
  input  logic              err_clr,
  output logic              busy,
  output logic [CNT_W-1:0]  layer_cnt,
  output logic              irq_done,
  output logic              err_timeout
);

  localparam int              WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_e          state;
  seq_state_e          state_nxt;
  logic [DESC_W-1:0]   shadow;
  logic [DESC_W-1:0]   fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [WD_W-1:0]     wd_cnt;
  logic                settle_cnt;
  logic [CNT_W-1:0]    layer_cnt_q;
  logic                err_q;
  logic [31:0]         opcfg;

  assign desc_ready  = !fifo_full;
  assign fifo_push   = desc_valid && desc_ready;
  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
  assign opcfg       = desc_word(shadow, OPCFG_LSB);
  assign busy        = (state != ST_IDLE) || !fifo_empty;
  assign irq_done    = (state == ST_WR_CLEAR) && fifo_empty;
  assign layer_cnt   = layer_cnt_q;
  assign err_timeout = err_q;

  dla_desc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (desc_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State, shadow descriptor, watchdog, settle timer, layer counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      shadow      <= '0;
      wd_cnt      <= '0;
      settle_cnt  <= 1'b0;
      layer_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) shadow <= fifo_rdata;
      wd_cnt     <= (state == ST_WAIT_DONE) ? wd_cnt + 1'b1 : '0;
      settle_cnt <= (state == ST_SETTLE) ? !settle_cnt : 1'b0;
      if (state == ST_WR_CLEAR) layer_cnt_q <= layer_cnt_q + 1'b1;
      if (state == ST_WAIT_DONE && !dla_done && wd_cnt == WD_LAST) err_q <= 1'b1;
      else if (state == ST_ERROR && err_clr) err_q <= 1'b0;
    end
  end

  // Next-state logic and Moore decode of the register write port.
  always_comb begin
    state_nxt      = state;
    ctrl_reg_w_en  = 1'b0;
    ctrl_reg_wsel  = WSEL_MAP;
    ctrl_reg_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_WR_MAP;
      end
      ST_WR_MAP: begin
        ctrl_reg_w_en  = 1'b1;
        ctrl_reg_wsel  = WSEL_MAP;
        ctrl_reg_wdata = desc_word(shadow, MAP_LSB);
        state_nxt      = ST_WR_SH1;
      end
      ST_WR_SH1: begin
        ctrl_reg_w_en  = 1'b1;
        ctrl_reg_wsel  = WSEL_SH1;
        ctrl_reg_wdata = desc_word(shadow, SH1_LSB);
        state_nxt      = ST_WR_SH2;
      end
      ST_WR_SH2: begin
        ctrl_reg_w_en  = 1'b1;
        ctrl_reg_wsel  = WSEL_SH2;
        ctrl_reg_wdata = desc_word(shadow, SH2_LSB);
        state_nxt      = ST_WR_START;
      end
      ST_WR_START: begin
        ctrl_reg_w_en  = 1'b1;
        ctrl_reg_wsel  = WSEL_OPCFG;
        ctrl_reg_wdata = opcfg | START_MASK;
        state_nxt      = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (dla_done)              state_nxt = ST_WR_CLEAR;
        else if (wd_cnt == WD_LAST) state_nxt = ST_ERROR;
      end
      ST_WR_CLEAR: begin
        ctrl_reg_w_en  = 1'b1;
        ctrl_reg_wsel  = WSEL_OPCFG;
        ctrl_reg_wdata = opcfg & ~START_MASK;
        state_nxt      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt) state_nxt = ST_IDLE;
      end
      ST_ERROR: begin
        if (err_clr) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dla_cmd_sequencer.sv
// tb/tb_dla_cmd_sequencer.sv - directed self-checking bench for dla_cmd_sequencer
module tb_dla_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              desc_valid = 1'b0;
  logic              desc_ready;
  logic [127:0]      desc_data = '0;
  logic              ctrl_reg_w_en;
  logic [1:0]        ctrl_reg_wsel;
  logic [31:0]       ctrl_reg_wdata;
  logic              dla_done = 1'b0;
  logic              err_clr = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  layer_cnt;
  logic              irq_done;
  logic              err_timeout;

  always #5 clk = ~clk;

  dla_cmd_sequencer #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_data      (desc_data),
    .ctrl_reg_w_en  (ctrl_reg_w_en),
    .ctrl_reg_wsel  (ctrl_reg_wsel),
    .ctrl_reg_wdata (ctrl_reg_wdata),
    .dla_done       (dla_done),
    .err_clr        (err_clr),
    .busy           (busy),
    .layer_cnt      (layer_cnt),
    .irq_done       (irq_done),
    .err_timeout    (err_timeout)
  );

  logic [33:0] wq [$];
  int          irq_cnt = 0;

  always @(posedge clk) begin
    if (ctrl_reg_w_en) wq.push_back({ctrl_reg_wsel, ctrl_reg_wdata});
    if (irq_done) irq_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [127:0] d);
    desc_valid = 1'b1;
    desc_data  = d;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  // Waits for an op_config write whose start bit equals sb; returns with ok=0 on timeout.
  task automatic wait_opcfg(input logic sb, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ctrl_reg_w_en && ctrl_reg_wsel == 2'd3 && ctrl_reg_wdata[0] == sb) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] op, input logic [31:0] sh2,
                                      input logic [31:0] sh1, input logic [31:0] map);
    return {op, sh2, sh1, map};
  endfunction

  logic [127:0] dt [5];
  logic [33:0]  e1 [5];
  logic [1:0]   cnt_seq [5];
  logic [127:0] dx, dy, dz, dw, dw2;
  logic [31:0]  op;
  logic         ok;
  int           base;
  int           ib;

  initial begin
    e1      = '{{2'd0, 32'h0001_2345}, {2'd1, 32'h0550_0000}, {2'd2, 32'h0000_0E0E},
                {2'd3, 32'h0000_0401}, {2'd3, 32'h0000_0400}};
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++)
      dt[i] = mk(32'h4000_0010 + 32'(i), 32'h3000_0000 + 32'(i),
                 32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i));
    dx  = mk(32'h0000_0A01, 32'h0000_0303, 32'h0000_0202, 32'h0000_0101);
    dy  = mk(32'h0000_0B00, 32'h0000_0606, 32'h0000_0505, 32'h0000_0404);
    dz  = mk(32'h0000_0C03, 32'h0000_0909, 32'h0000_0808, 32'h0000_0707);
    dw  = mk(32'h0000_0D00, 32'h0000_0C0C, 32'h0000_0B0B, 32'h0000_0A0A);
    dw2 = mk(32'h0000_0E00, 32'h0000_0F0F, 32'h0000_0E0E, 32'h0000_0D0D);

    // Reset values
    @(negedge clk);
    chk("rst_ready", 64'(desc_ready), 64'd1);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_wen",   64'(ctrl_reg_w_en), 64'd0);
    chk("rst_wsel",  64'(ctrl_reg_wsel), 64'd0);
    chk("rst_wdata", 64'(ctrl_reg_wdata), 64'd0);
    chk("rst_cnt",   64'(layer_cnt), 64'd0);
    chk("rst_irq",   64'(irq_done), 64'd0);
    chk("rst_err",   64'(err_timeout), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single descriptor
    base = wq.size();
    ib   = irq_cnt;
    push(mk(32'h0000_0400, 32'h0000_0E0E, 32'h0550_0000, 32'h0001_2345));
    chk("t1_wen_early", 64'(ctrl_reg_w_en), 64'd0);
    chk("t1_busy",      64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_map_wen",   64'(ctrl_reg_w_en), 64'd1);
    chk("t1_map_wsel",  64'(ctrl_reg_wsel), 64'd0);
    chk("t1_map_wdata", 64'(ctrl_reg_wdata), 64'h0001_2345);
    cyc(3);
    chk("t1_start_wsel",  64'(ctrl_reg_wsel), 64'd3);
    chk("t1_start_wdata", 64'(ctrl_reg_wdata), 64'h0000_0401);
    cyc(10);
    chk("t1_wait_wen", 64'(ctrl_reg_w_en), 64'd0);
    dla_done = 1'b1;
    @(negedge clk);
    chk("t1_clr_wen",   64'(ctrl_reg_w_en), 64'd1);
    chk("t1_clr_wsel",  64'(ctrl_reg_wsel), 64'd3);
    chk("t1_clr_wdata", 64'(ctrl_reg_wdata), 64'h0000_0400);
    chk("t1_irq_on",    64'(irq_done), 64'd1);
    dla_done = 1'b0;
    @(negedge clk);
    chk("t1_cnt",     64'(layer_cnt), 64'd1);
    chk("t1_irq_off", 64'(irq_done), 64'd0);
    cyc(2);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_nwrites", 64'(wq.size() - base), 64'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < wq.size()) chk("t1_write", 64'(wq[base + i]), 64'(e1[i]));
    chk("t1_irq_count", 64'(irq_cnt - ib), 64'd1);

    // Five descriptors with the sequencer stalled, counter wraps
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = wq.size();
    ib   = irq_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("t2_ready_before_push", 64'(desc_ready), 64'd1);
      push(dt[i]);
    end
    chk("t2_ready_full", 64'(desc_ready), 64'd0);
    desc_valid = 1'b1;
    desc_data  = mk(32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004);
    cyc(2);
    chk("t2_ready_still_full", 64'(desc_ready), 64'd0);
    desc_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dla_done = 1'b1;
      wait_opcfg(1'b0, ok);
      chk("t2_clear_seen", 64'(ok), 64'd1);
      chk("t2_irq", 64'(irq_done), 64'(k == 4));
      dla_done = 1'b0;
      @(negedge clk);
      chk("t2_layer_cnt", 64'(layer_cnt), 64'(cnt_seq[k]));
    end
    cyc(2);
    chk("t2_idle_busy", 64'(busy), 64'd0);
    chk("t2_nwrites", 64'(wq.size() - base), 64'd25);
    for (int i = 0; i < 5; i++) begin
      op = dt[i][127:96];
      if (base + 5 * i + 4 < wq.size()) begin
        chk("t2_w_map", 64'(wq[base + 5 * i + 0]), 64'({2'd0, dt[i][31:0]}));
        chk("t2_w_sh1", 64'(wq[base + 5 * i + 1]), 64'({2'd1, dt[i][63:32]}));
        chk("t2_w_sh2", 64'(wq[base + 5 * i + 2]), 64'({2'd2, dt[i][95:64]}));
        chk("t2_w_st",  64'(wq[base + 5 * i + 3]), 64'({2'd3, op | 32'd1}));
        chk("t2_w_clr", 64'(wq[base + 5 * i + 4]), 64'({2'd3, op & ~32'd1}));
      end
    end
    chk("t2_irq_count", 64'(irq_cnt - ib), 64'd1);

    // Watchdog timeout, recovery with err_clr
    base = wq.size();
    push(dx);
    wait_opcfg(1'b1, ok);
    chk("t3_start_seen", 64'(ok), 64'd1);
    cyc(TIMEOUT);
    chk("t3_err_before", 64'(err_timeout), 64'd0);
    @(negedge clk);
    chk("t3_err_set", 64'(err_timeout), 64'd1);
    chk("t3_err_busy", 64'(busy), 64'd1);
    chk("t3_err_wen", 64'(ctrl_reg_w_en), 64'd0);
    chk("t3_ready", 64'(desc_ready), 64'd1);
    push(dy);
    cyc(4);
    chk("t3_no_writes", 64'(wq.size() - base), 64'd4);
    chk("t3_err_sticky", 64'(err_timeout), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t3_err_cleared", 64'(err_timeout), 64'd0);
    @(negedge clk);
    chk("t3_next_wen",   64'(ctrl_reg_w_en), 64'd1);
    chk("t3_next_wsel",  64'(ctrl_reg_wsel), 64'd0);
    chk("t3_next_wdata", 64'(ctrl_reg_wdata), 64'h0000_0404);
    dla_done = 1'b1;
    wait_opcfg(1'b0, ok);
    chk("t3_clear_seen", 64'(ok), 64'd1);
    chk("t3_clear_wdata", 64'(ctrl_reg_wdata), 64'h0000_0B00);
    dla_done = 1'b0;
    cyc(3);
    chk("t3_layer_cnt", 64'(layer_cnt), 64'd2);
    chk("t3_idle_busy", 64'(busy), 64'd0);

    // dla_done on the last watchdog cycle wins over the timeout
    push(dz);
    wait_opcfg(1'b1, ok);
    chk("t4_start_seen", 64'(ok), 64'd1);
    cyc(TIMEOUT);
    dla_done = 1'b1;
    @(negedge clk);
    chk("t4_clr_wen",   64'(ctrl_reg_w_en), 64'd1);
    chk("t4_clr_wsel",  64'(ctrl_reg_wsel), 64'd3);
    chk("t4_clr_wdata", 64'(ctrl_reg_wdata), 64'h0000_0C02);
    chk("t4_err",       64'(err_timeout), 64'd0);
    dla_done = 1'b0;
    @(negedge clk);
    chk("t4_err_after", 64'(err_timeout), 64'd0);
    chk("t4_layer_cnt", 64'(layer_cnt), 64'd3);
    cyc(2);

    // Asynchronous reset in the middle of a write sequence
    desc_valid = 1'b1;
    desc_data  = dw;
    @(negedge clk);
    desc_data  = dw2;
    @(negedge clk);
    desc_valid = 1'b0;
    @(negedge clk);
    chk("t5_in_sh1_wsel",  64'(ctrl_reg_wsel), 64'd1);
    chk("t5_in_sh1_wdata", 64'(ctrl_reg_wdata), 64'h0000_0B0B);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_wen",   64'(ctrl_reg_w_en), 64'd0);
    chk("t5_wsel",  64'(ctrl_reg_wsel), 64'd0);
    chk("t5_wdata", 64'(ctrl_reg_wdata), 64'd0);
    chk("t5_busy",  64'(busy), 64'd0);
    chk("t5_ready", 64'(desc_ready), 64'd1);
    chk("t5_cnt",   64'(layer_cnt), 64'd0);
    chk("t5_irq",   64'(irq_done), 64'd0);
    chk("t5_err",   64'(err_timeout), 64'd0);
    cyc(2);
    rst  = 1'b0;
    base = wq.size();
    cyc(8);
    chk("t5_no_writes", 64'(wq.size() - base), 64'd0);
    chk("t5_busy_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
